// File: rtl/lcd_pkg.sv
// Shared mode encoding and colour constants for the RGB-LCD timing and pattern generator.
package lcd_pkg;

  typedef enum logic [1:0] {
    BARS   = 2'd0,
    GRID   = 2'd1,
    SOLID  = 2'd2,
    MOVING = 2'd3
  } lcd_mode_t;

  // Colours are {r, g, b} on/off flags; each flag expands to a full-scale channel.
  typedef logic [2:0] colour_flags_t;

  localparam colour_flags_t ColWhite   = 3'b111;
  localparam colour_flags_t ColYellow  = 3'b110;
  localparam colour_flags_t ColCyan    = 3'b011;
  localparam colour_flags_t ColGreen   = 3'b010;
  localparam colour_flags_t ColMagenta = 3'b101;
  localparam colour_flags_t ColRed     = 3'b100;
  localparam colour_flags_t ColBlue    = 3'b001;
  localparam colour_flags_t ColBlack   = 3'b000;

  // Index 0 is the leftmost bar.
  localparam colour_flags_t [7:0] BarColours = {
    ColBlack, ColBlue, ColRed, ColMagenta, ColGreen, ColCyan, ColYellow, ColWhite
  };

  localparam int unsigned NumBars    = 8;
  localparam int unsigned MovingBarW = 16;

endpackage

// File: rtl/lcd_pattern_gen.sv
// Test-pattern source: maps the current pixel position and shadowed mode to an RGB word.
// Only the colour-bar tracker is stateful; everything else is combinational.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_TOTAL  = 525,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9,
  parameter int unsigned R_W      = 5,
  parameter int unsigned G_W      = 6,
  parameter int unsigned B_W      = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     pix_ce_i,
  input  logic [XW-1:0]            x_i,
  input  logic [YW-1:0]            y_i,
  input  logic                     active_i,
  input  lcd_mode_t                mode_i,
  input  logic [R_W+G_W+B_W-1:0]   solid_i,
  input  logic [XW-1:0]            bar_pos_i,
  output logic [R_W+G_W+B_W-1:0]   rgb_o
);

  localparam int unsigned BarW = H_ACTIVE / NumBars;
  localparam int unsigned BW   = (BarW > 1) ? $clog2(BarW) : 1;

  localparam logic [XW-1:0] XLast      = XW'(H_TOTAL - 1);
  localparam logic [BW-1:0] BarCntLast = BW'(BarW - 1);

  function automatic logic [R_W+G_W+B_W-1:0] expand(input colour_flags_t f);
    return {{R_W{f[2]}}, {G_W{f[1]}}, {B_W{f[0]}}};
  endfunction

  logic [BW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  // The last bar absorbs the remainder of H_ACTIVE/8 by simply never advancing past it.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (pix_ce_i) begin
      if (x_i == XLast) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (bar_idx_q != 3'd7) begin
        if (bar_cnt_q == BarCntLast) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  logic            grid_on;
  logic            bar_on;
  logic [XW+4:0]   x_ext;
  logic [XW+4:0]   bar_lo;
  logic [XW+4:0]   bar_hi;

  always_comb begin
    grid_on = ((x_i & XW'(15)) == '0) || ((y_i & YW'(15)) == '0);
    // Widened so a bar starting near the line end does not wrap.
    x_ext   = {5'd0, x_i};
    bar_lo  = {5'd0, bar_pos_i};
    bar_hi  = bar_lo + (XW + 5)'(MovingBarW);
    bar_on  = (x_ext >= bar_lo) && (x_ext < bar_hi);
  end

  always_comb begin
    rgb_o = '0;
    if (active_i) begin
      case (mode_i)
        BARS:    rgb_o = expand(BarColours[bar_idx_q]);
        GRID:    rgb_o = grid_on ? expand(ColWhite) : expand(ColBlack);
        SOLID:   rgb_o = solid_i;
        MOVING:  rgb_o = bar_on ? expand(ColWhite) : expand(ColBlue);
        default: rgb_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB-LCD timing generator: pixel-clock divider, h/v counters, sync decode, frame-aligned
// pattern shadowing and the registered panel outputs.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 2,
  parameter int unsigned CLK_DIV  = 10,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned R_W      = 5,
  parameter int unsigned G_W      = 6,
  parameter int unsigned B_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [R_W+G_W+B_W-1:0] solid_rgb,
  output logic                   lcd_clk,
  output logic                   lcd_de,
  output logic                   lcd_hsync,
  output logic                   lcd_vsync,
  output logic [R_W-1:0]         lcd_r,
  output logic [G_W-1:0]         lcd_g,
  output logic [B_W-1:0]         lcd_b,
  output logic                   frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned RGB_W   = R_W + G_W + B_W;
  localparam int unsigned XW      = $clog2(H_TOTAL + 1);
  localparam int unsigned YW      = $clog2(V_TOTAL + 1);
  localparam int unsigned DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DivLast  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DivHalf  = DW'(CLK_DIV / 2);
  localparam logic [XW-1:0] XLast    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] XActEnd  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] XActLast = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] XSyncBeg = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] XSyncEnd = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] YLast    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] YActEnd  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] YSyncBeg = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] YSyncEnd = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]    div_q, div_d;
  logic             lcd_clk_q, lcd_clk_d;
  logic [XW-1:0]    h_q, h_d;
  logic [YW-1:0]    v_q, v_d;
  lcd_mode_t        mode_sh_q, mode_sh_d;
  logic [RGB_W-1:0] solid_sh_q, solid_sh_d;
  logic [XW-1:0]    bar_pos_q, bar_pos_d;
  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             fs_q, fs_d;

  logic             pix_ce;
  logic             line_end;
  logic             frame_end;
  logic             active;
  logic             hs_on;
  logic             vs_on;
  logic [RGB_W-1:0] pat_rgb;

  always_comb begin
    pix_ce    = (div_q == DivLast);
    line_end  = pix_ce && (h_q == XLast);
    frame_end = line_end && (v_q == YLast);
    active    = (h_q < XActEnd) && (v_q < YActEnd);
    hs_on     = (h_q >= XSyncBeg) && (h_q < XSyncEnd);
    vs_on     = (v_q >= YSyncBeg) && (v_q < YSyncEnd);
  end

  lcd_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .XW       (XW),
    .YW       (YW),
    .R_W      (R_W),
    .G_W      (G_W),
    .B_W      (B_W)
  ) u_pattern (
    .clk_i     (clk),
    .rst_ni    (rst),
    .pix_ce_i  (pix_ce),
    .x_i       (h_q),
    .y_i       (v_q),
    .active_i  (active),
    .mode_i    (mode_sh_q),
    .solid_i   (solid_sh_q),
    .bar_pos_i (bar_pos_q),
    .rgb_o     (pat_rgb)
  );

  always_comb begin
    div_d      = pix_ce ? '0 : div_q + DW'(1);
    // Registered compare against the next divider value keeps lcd_clk glitch-free.
    lcd_clk_d  = (div_d >= DivHalf);
    h_d        = h_q;
    v_d        = v_q;
    mode_sh_d  = mode_sh_q;
    solid_sh_d = solid_sh_q;
    bar_pos_d  = bar_pos_q;
    de_d       = de_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    rgb_d      = rgb_q;
    fs_d       = 1'b0;

    if (pix_ce) begin
      h_d   = (h_q == XLast) ? '0 : h_q + XW'(1);
      de_d  = active;
      hs_d  = hs_on ? HS_POL : ~HS_POL;
      vs_d  = vs_on ? VS_POL : ~VS_POL;
      rgb_d = active ? pat_rgb : '0;
      fs_d  = (h_q == '0) && (v_q == '0);
    end

    if (line_end) begin
      v_d = (v_q == YLast) ? '0 : v_q + YW'(1);
    end

    // Pattern inputs are latched only at the frame wrap so a frame never tears.
    if (frame_end) begin
      mode_sh_d  = lcd_mode_t'(mode);
      solid_sh_d = solid_rgb;
      bar_pos_d  = (bar_pos_q == XActLast) ? '0 : bar_pos_q + XW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      lcd_clk_q  <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      mode_sh_q  <= BARS;
      solid_sh_q <= '0;
      bar_pos_q  <= '0;
      de_q       <= 1'b0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      rgb_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      lcd_clk_q  <= lcd_clk_d;
      h_q        <= h_d;
      v_q        <= v_d;
      mode_sh_q  <= mode_sh_d;
      solid_sh_q <= solid_sh_d;
      bar_pos_q  <= bar_pos_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
      fs_q       <= fs_d;
    end
  end

  assign lcd_clk               = lcd_clk_q;
  assign lcd_de                = de_q;
  assign lcd_hsync             = hs_q;
  assign lcd_vsync             = vs_q;
  assign {lcd_r, lcd_g, lcd_b} = rgb_q;
  assign frame_start           = fs_q;

endmodule
